vga_sync_gen: RTL and testbench

Upstream timing stage for all on-screen objects (ball, paddles, colour mux). It generates 640x480@60 Hz VGA timing from the system clock. It drives the pixel coordinates hsp/vsp that object blocks compare against, plus hsync/vsync, video_on and per-line/per-frame strobes. All outputs are registered and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_sync_gen_if.sv | 21 ++
 rtl/clk_enable_div.sv | 27 ++
 rtl/vga_sync_gen.sv | 87 ++++++++
 tb/tb_vga_sync_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 default timing constants shared by the display blocks
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // Sync windows are half-open: START inclusive, END exclusive.
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    function automatic logic in_span(input logic [COORD_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - timing bus from the sync generator to the on-screen object blocks
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] hsp;
    logic [COORD_W-1:0] vsp;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               pix_tick;
    logic               line_start;
    logic               frame_start;

    modport master (
        output hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );

    modport slave (
        input hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );
endinterface

// File: rtl/clk_enable_div.sv
// rtl/clk_enable_div.sv - registered one-clock enable pulse every CLK_DIV system clocks
module clk_enable_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + ONE;
            tick    <= 1'b0;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel/line counters with registered sync, blanking and strobes
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV     = 2,
    parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK      = vga_timing_pkg::H_BACK,
    parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO = H_VISIBLE + H_FRONT;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_VISIBLE + V_FRONT;
    localparam int VS_HI = VS_LO + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    logic               pix_tick;
    logic [COORD_W-1:0] hsp, vsp;
    logic [COORD_W-1:0] hsp_nxt, vsp_nxt;
    logic               hsync, vsync, video_on, line_start, frame_start;

    clk_enable_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk   (clk),
        .reset (reset),
        .tick  (pix_tick)
    );

    always_comb begin
        hsp_nxt = hsp;
        vsp_nxt = vsp;
        if (pix_tick) begin
            if (hsp == H_LAST) begin
                hsp_nxt = '0;
                vsp_nxt = (vsp == V_LAST) ? '0 : vsp + ONE;
            end else begin
                hsp_nxt = hsp + ONE;
            end
        end
    end

    // Decode from the next-state counters so each flag lands with the coordinate it describes.
    // Flags only refresh on a tick, which keeps the first-frame (0,0) out of the visible area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsp         <= '0;
            vsp         <= '0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsp         <= hsp_nxt;
            vsp         <= vsp_nxt;
            line_start  <= pix_tick && (hsp_nxt == '0);
            frame_start <= pix_tick && (hsp_nxt == '0) && (vsp_nxt == '0);
            if (pix_tick) begin
                hsync    <= in_span(hsp_nxt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync    <= in_span(vsp_nxt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                video_on <= in_span(hsp_nxt, 0, H_VISIBLE) && in_span(vsp_nxt, 0, V_VISIBLE);
            end
        end
    end

    assign vga.hsp         = hsp;
    assign vga.vsp         = vsp;
    assign vga.hsync       = hsync;
    assign vga.vsync       = vsync;
    assign vga.video_on    = video_on;
    assign vga.pix_tick    = pix_tick;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen at three divider/geometry settings
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] hsp;
        logic [9:0] vsp;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       pix_tick;
        logic       line_start;
        logic       frame_start;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst = 3'b111;
    int   n [3];
    obs_t q0 [$];
    obs_t q1 [$];
    obs_t q2 [$];
    int   checks = 0;
    int   failures = 0;
    event async_ev;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();
    vga_sync_gen_if bus_c ();

    vga_sync_gen dut_a (.clk(clk), .reset(rst[0]), .vga(bus_a));

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
    ) dut_b (.clk(clk), .reset(rst[1]), .vga(bus_b));

    vga_sync_gen #(
        .CLK_DIV(3), .H_VISIBLE(12), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
    ) dut_c (.clk(clk), .reset(rst[2]), .vga(bus_c));

    // cnt = clock edges seen since reset release (0 while in reset).
    // Tick k is registered on edge k*d and the counters move on the edge after it.
    function automatic obs_t model(int cnt, int d, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        obs_t e;
        int ht, vt, p, h, v;
        bit moved;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        p  = (cnt >= 1) ? (cnt - 1) / d : 0;
        h  = p % ht;
        v  = (p / ht) % vt;
        moved = (p > 0) && ((cnt - 1) % d == 0);
        e.hsp         = 10'(h);
        e.vsp         = 10'(v);
        e.pix_tick    = (cnt >= 1) && (cnt % d == 0);
        e.hsync       = !((p > 0) && (h >= hv + hf) && (h < hv + hf + hs));
        e.vsync       = !((p > 0) && (v >= vv + vf) && (v < vv + vf + vs));
        e.video_on    = (p > 0) && (h < hv) && (v < vv);
        e.line_start  = moved && (h == 0);
        e.frame_start = moved && (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic obs_t expect_for(int i);
        case (i)
            0:       return model(n[0], 2, 640, 16, 96, 48, 480, 10, 2, 33);
            1:       return model(n[1], 1, 12, 3, 5, 4, 6, 2, 2, 3);
            default: return model(n[2], 3, 12, 3, 5, 4, 6, 2, 2, 3);
        endcase
    endfunction

    task automatic push_all();
        q0.push_back(expect_for(0));
        q1.push_back(expect_for(1));
        q2.push_back(expect_for(2));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) n[i] = rst[i] ? 0 : n[i] + 1;
        #1;
        push_all();
    endtask

    task automatic async_reset(input logic [2:0] mask);
        @(negedge clk);
        #2;
        rst = rst | mask;
        for (int i = 0; i < 3; i++) if (mask[i]) n[i] = 0;
        #1;
        push_all();
        -> async_ev;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got hsp=%0d vsp=%0d hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b expected hsp=%0d vsp=%0d hs=%b vs=%b vid=%b tick=%b ls=%b fs=%b",
                     name, $time, act.hsp, act.vsp, act.hsync, act.vsync, act.video_on,
                     act.pix_tick, act.line_start, act.frame_start, exp.hsp, exp.vsp,
                     exp.hsync, exp.vsync, exp.video_on, exp.pix_tick, exp.line_start,
                     exp.frame_start);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or async_ev);
            if (q0.size() > 0)
                check("dut_a", {bus_a.hsp, bus_a.vsp, bus_a.hsync, bus_a.vsync, bus_a.video_on,
                                bus_a.pix_tick, bus_a.line_start, bus_a.frame_start}, q0.pop_front());
            if (q1.size() > 0)
                check("dut_b", {bus_b.hsp, bus_b.vsp, bus_b.hsync, bus_b.vsync, bus_b.video_on,
                                bus_b.pix_tick, bus_b.line_start, bus_b.frame_start}, q1.pop_front());
            if (q2.size() > 0)
                check("dut_c", {bus_c.hsp, bus_c.vsp, bus_c.hsync, bus_c.vsync, bus_c.video_on,
                                bus_c.pix_tick, bus_c.line_start, bus_c.frame_start}, q2.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   guard;
        int   len;
        int   hold;
        obs_t eb;
        logic [2:0] mask;

        n = '{0, 0, 0};
        repeat (5) step();
        rst = 3'b000;
        repeat (1800) step();

        // Land dut_b inside both sync pulses, then pull reset asynchronously.
        guard = 0;
        eb = expect_for(1);
        while (!(eb.hsp == 10'd17 && eb.vsp == 10'd9) && guard < 2000) begin
            step();
            eb = expect_for(1);
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            failures++;
            $display("FAIL sync_target_wait got guard=%0d expected below 2000", guard);
        end
        async_reset(3'b010);
        repeat (3) step();
        rst = 3'b000;

        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(3000, 200);
            hold = $urandom_range(4, 1);
            mask = 3'($urandom_range(7, 1));
            repeat (len) step();
            async_reset(mask);
            repeat (hold) step();
            rst = 3'b000;
        end

        repeat (2000) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
